// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the result_display slice: the converter FSM
// state type, the blank segment pattern, the digit-to-segment table and the
// number of BCD digits produced by the converter.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } convState_e;

    localparam int BCD_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n holds the pattern for decimal digit n (entry 9 is listed first).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Anything that is not a decimal digit decodes to a dark digit rather
    // than indexing past the end of the table.
    function automatic logic [6:0] segEncode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_TABLE[digit];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter
// Iterative shift-add-3 (double-dabble) binary to BCD converter with a
// one-entry pending buffer so loads arriving mid-conversion are never lost.
// Ports:
//   clock_i   system clock, rising edge
//   reset_i   synchronous active-high reset
//   value_i   8-bit unsigned value, sampled when load_i is high
//   load_i    single-cycle load strobe
//   busy_o    registered, high while a conversion is in progress
//   done_o    one-cycle pulse while the FSM sits in DONE; digits_o is the
//             finished result during that cycle
//   digits_o  {hundreds, tens, units} as 4-bit nibbles
// ---------------------------------------------------------------------------
module bcd_converter
    import display_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  value_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] digits_o
);

    convState_e  state_q, state_d;
    logic [7:0]  shiftReg_q, shiftReg_d;
    logic [9:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pendVal_q, pendVal_d;
    logic        busy_q, busy_d;

    logic [3:0]  unitsAdj;
    logic [3:0]  tensAdj;
    logic [17:0] shiftedBits;

    // One double-dabble step: correct units and tens, then shift the whole
    // BCD:binary chain left. Hundreds is only 2 bits wide and never exceeds
    // 2, so it never needs the +3 correction.
    always_comb begin
        unitsAdj    = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        tensAdj     = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        shiftedBits = {bcd_q[9:8], tensAdj, unitsAdj, shiftReg_q} << 1;
    end

    // Next-state logic. In DONE a pending value or a load on that same edge
    // restarts the engine immediately, so back-to-back conversions have no
    // IDLE gap; a same-edge load is newer than any pending value and wins.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pendVal_d  = pendVal_q;
        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    shiftReg_d = value_i;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d      = shiftedBits[17:8];
                shiftReg_d = shiftedBits[7:0];
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
                if (load_i) begin
                    pend_d    = 1'b1;
                    pendVal_d = value_i;
                end
            end
            DONE: begin
                if (load_i || pend_q) begin
                    shiftReg_d = load_i ? value_i : pendVal_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register; reset aborts any conversion and drops the pending value.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pendVal_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pendVal_q  <= pendVal_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = (state_q == DONE);
    assign digits_o = {2'b00, bcd_q};

endmodule

// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
// Captures an 8-bit value, converts it to three BCD digits and scans them
// onto a 4-digit common-anode seven-segment display. The fourth slot is kept
// dark so every digit gets the same duty cycle.
// Optional feature: define RESULT_DISPLAY_LZB_EN for leading-zero blanking
// (hundreds blank when 0, tens blank when hundreds and tens are both 0;
// units always shown). Blanking only alters seg_o, never timing or an_o.
// Parameters:
//   REFRESH_CYCLES  cycles each position is lit (>= 2)
// Ports:
//   clock_i   system clock, rising edge
//   reset_i   synchronous active-high reset
//   value_i   8-bit unsigned value to display
//   load_i    single-cycle load strobe
//   busy_o    high while a conversion is in progress
//   an_o      digit anodes, active-low, bit 0 = rightmost digit
//   seg_o     segments {g,f,e,d,c,b,a}, active-low
//   dp_o      decimal point, active-low, always off
// ---------------------------------------------------------------------------
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] value_i,
    input  logic       load_i,
    output logic       busy_o,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

`ifdef RESULT_DISPLAY_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    localparam int RCNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    logic              convDone;
    logic [11:0]       convDigits;

    logic [11:0]       digits_q, digits_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [1:0]        pos_q, pos_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [3:0]        digit;
    logic              blank;

    bcd_converter u_conv (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .value_i  (value_i),
        .load_i   (load_i),
        .busy_o   (busy_o),
        .done_o   (convDone),
        .digits_o (convDigits)
    );

    // The displayed digits only change on a finished conversion, and the
    // scan registers sample them once per cycle, so a seg value never mixes
    // old and new results.
    always_comb begin
        digits_d = convDone ? convDigits : digits_q;
        rcnt_d   = rcnt_q + RCNT_W'(1);
        pos_d    = pos_q;
        if (rcnt_q == RCNT_W'(REFRESH_CYCLES - 1)) begin
            rcnt_d = '0;
            pos_d  = pos_q + 2'd1;
        end
    end

    // Anode/segment selection for the current scan position. A blanked digit
    // keeps its anode on with all segments dark.
    always_comb begin
        an_d  = 4'b1111;
        digit = 4'd0;
        blank = 1'b1;
        unique case (pos_q)
            2'd0: begin
                an_d  = 4'b1110;
                digit = digits_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                an_d  = 4'b1101;
                digit = digits_q[7:4];
                blank = LZB_EN && (digits_q[11:4] == 8'd0);
            end
            2'd2: begin
                an_d  = 4'b1011;
                digit = digits_q[11:8];
                blank = LZB_EN && (digits_q[11:8] == 4'd0);
            end
            default: begin
                an_d  = 4'b1111;
                blank = 1'b1;
            end
        endcase
        seg_d = blank ? SEG_BLANK : segEncode(digit);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            digits_q <= '0;
            rcnt_q   <= '0;
            pos_q    <= '0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_BLANK;
        end else begin
            digits_q <= digits_d;
            rcnt_q   <= rcnt_d;
            pos_q    <= pos_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = 1'b1;

endmodule
